// File: rtl/hue_stage1.sv
// hue_stage1: RGB -> max/min/delta, then a pipelined restoring divide of the channel-difference numerator by delta.
// Latency FRAC_W+3, 1 pixel/clock, no backpressure. Define HUE_SV_OUT_EN to add the aligned o_max/o_delta outputs.
module hue_stage1 #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic [DATA_W-1:0] i_red,
  input  logic [DATA_W-1:0] i_green,
  input  logic [DATA_W-1:0] i_blue,
  input  logic              i_valid,
  output logic [15:0]       o_data,
  output logic [1:0]        o_function,
  output logic              o_valid
`ifdef HUE_SV_OUT_EN
  ,
  output logic [DATA_W-1:0] o_max,
  output logic [DATA_W-1:0] o_delta
`endif
);

  localparam int NST = FRAC_W + 1;  // one division stage per quotient bit
  localparam int QW  = FRAC_W + 1;

  logic [DATA_W-1:0] w_max, w_min, w_delta, w_na, w_nb, w_mag;
  logic [1:0]        w_func;
  logic              w_sign;

  always_comb begin
    w_max  = i_red;
    w_na   = i_green;
    w_nb   = i_blue;
    w_func = 2'd1;
    if (i_red >= i_green && i_red >= i_blue) begin
      w_max  = i_red;
      w_na   = i_green;
      w_nb   = i_blue;
      w_func = 2'd1;
    end else if (i_green >= i_blue) begin
      w_max  = i_green;
      w_na   = i_blue;
      w_nb   = i_red;
      w_func = 2'd2;
    end else begin
      w_max  = i_blue;
      w_na   = i_red;
      w_nb   = i_green;
      w_func = 2'd3;
    end
    w_min = i_red;
    if (i_green < w_min) w_min = i_green;
    if (i_blue < w_min)  w_min = i_blue;
    w_delta = w_max - w_min;
    w_sign  = (w_na < w_nb);
    w_mag   = w_sign ? (w_nb - w_na) : (w_na - w_nb);
    if (w_delta == '0) w_func = 2'd0;
  end

  logic [DATA_W-1:0] r_rem  [0:NST-1];
  logic [DATA_W-1:0] r_div  [0:NST-1];
  logic [QW-1:0]     r_quo  [0:NST];
  logic              r_sign [0:NST];
  logic [1:0]        r_func [0:NST];
  logic              r_vld  [0:NST];

  logic [DATA_W:0]   w_trial [1:NST];
  logic              w_ge    [1:NST];
  logic [DATA_W-1:0] w_sub   [1:NST-1];

  // The first step compares |num| directly (quotient bit FRAC_W); later steps shift first.
  // A successful subtract always leaves less than the divisor, so the low DATA_W bits suffice.
  always_comb begin
    for (int i = 1; i <= NST; i++) begin
      w_trial[i] = (i == 1) ? {1'b0, r_rem[i-1]} : {r_rem[i-1], 1'b0};
      w_ge[i]    = (w_trial[i] >= {1'b0, r_div[i-1]});
    end
    for (int i = 1; i < NST; i++) begin
      w_sub[i] = w_trial[i][DATA_W-1:0] - r_div[i-1];
    end
  end

  logic [15:0] w_qext;
  logic [15:0] r_res;
  logic [1:0]  r_res_func;
  logic        r_res_vld;

  assign w_qext = {{(16-QW){1'b0}}, r_quo[NST]};

`ifdef HUE_SV_OUT_EN
  logic [DATA_W-1:0] r_pmax [0:NST+1];
  logic [DATA_W-1:0] r_pdlt [0:NST+1];
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NST; i++) begin
        r_rem[i] <= '0;
        r_div[i] <= '0;
      end
      for (int i = 0; i <= NST; i++) begin
        r_quo[i]  <= '0;
        r_sign[i] <= 1'b0;
        r_func[i] <= 2'd0;
        r_vld[i]  <= 1'b0;
      end
      r_res      <= '0;
      r_res_func <= 2'd0;
      r_res_vld  <= 1'b0;
      o_data     <= '0;
      o_function <= 2'd0;
      o_valid    <= 1'b0;
`ifdef HUE_SV_OUT_EN
      for (int i = 0; i <= NST + 1; i++) begin
        r_pmax[i] <= '0;
        r_pdlt[i] <= '0;
      end
      o_max   <= '0;
      o_delta <= '0;
`endif
    end else begin
      r_rem[0]  <= w_mag;
      r_div[0]  <= (w_delta == '0) ? DATA_W'(1) : w_delta;
      r_quo[0]  <= '0;
      r_sign[0] <= w_sign;
      r_func[0] <= w_func;
      r_vld[0]  <= i_valid;
      for (int i = 1; i <= NST; i++) begin
        r_quo[i]         <= r_quo[i-1];
        r_quo[i][QW-i]   <= w_ge[i];
        r_sign[i]        <= r_sign[i-1];
        r_func[i]        <= r_func[i-1];
        r_vld[i]         <= r_vld[i-1];
      end
      for (int i = 1; i < NST; i++) begin
        r_rem[i] <= w_ge[i] ? w_sub[i] : w_trial[i][DATA_W-1:0];
        r_div[i] <= r_div[i-1];
      end
      if (r_func[NST] == 2'd0)
        r_res <= '0;
      else
        r_res <= r_sign[NST] ? -w_qext : w_qext;
      r_res_func <= r_func[NST];
      r_res_vld  <= r_vld[NST];
      o_valid    <= r_res_vld;
      if (r_res_vld) begin
        o_data     <= r_res;
        o_function <= r_res_func;
      end
`ifdef HUE_SV_OUT_EN
      r_pmax[0] <= w_max;
      r_pdlt[0] <= w_delta;
      for (int i = 1; i <= NST + 1; i++) begin
        r_pmax[i] <= r_pmax[i-1];
        r_pdlt[i] <= r_pdlt[i-1];
      end
      if (r_res_vld) begin
        o_max   <= r_pmax[NST+1];
        o_delta <= r_pdlt[NST+1];
      end
`endif
    end
  end

endmodule

// File: tb/tb_hue_stage1.sv
// Randomised bench for hue_stage1 against an arithmetic hue-numerator/delta model with a latency queue.
module tb_hue_stage1;

  localparam int DW  = 8;
  localparam int FW  = 6;
  localparam int LAT = FW + 3;

  logic          i_clk   = 1'b0;
  logic          i_rstn  = 1'b0;
  logic [DW-1:0] i_red   = '0;
  logic [DW-1:0] i_green = '0;
  logic [DW-1:0] i_blue  = '0;
  logic          i_valid = 1'b0;
  logic [15:0]   o_data;
  logic [1:0]    o_function;
  logic          o_valid;
`ifdef HUE_SV_OUT_EN
  logic [DW-1:0] o_max;
  logic [DW-1:0] o_delta;
`endif

  hue_stage1 #(.DATA_W(DW), .FRAC_W(FW)) dut (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_red      (i_red),
    .i_green    (i_green),
    .i_blue     (i_blue),
    .i_valid    (i_valid),
    .o_data     (o_data),
    .o_function (o_function),
    .o_valid    (o_valid)
`ifdef HUE_SV_OUT_EN
    ,
    .o_max      (o_max),
    .o_delta    (o_delta)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          v;
    logic [1:0]  fn;
    logic [15:0] d;
    logic [7:0]  mx;
    logic [7:0]  dl;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  h_fn;
  logic [15:0] h_d;
  logic [7:0]  h_mx, h_dl;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Hue numerator over delta, truncated toward zero, scaled by 2^FW.
  function automatic void ref_px(input int r, input int g, input int b,
                                 output int fn, output int q, output int mx, output int dl);
    int mn, num, an;
    mx = (r > g) ? r : g;
    mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    dl = mx - mn;
    if (r >= g && r >= b) begin fn = 1; num = g - b; end
    else if (g >= b)      begin fn = 2; num = b - r; end
    else                  begin fn = 3; num = r - g; end
    if (dl == 0) begin
      fn = 0;
      q  = 0;
    end else begin
      an = (num < 0) ? -num : num;
      q  = (an * (1 << FW)) / dl;
      if (num < 0) q = -q;
    end
  endfunction

  task automatic model_reset();
    exp_t e;
    e.v = 1'b0; e.fn = '0; e.d = '0; e.mx = '0; e.dl = '0;
    exp_q.delete();
    for (int k = 0; k < LAT; k++) exp_q.push_back(e);
    h_fn = '0; h_d = '0; h_mx = '0; h_dl = '0;
  endtask

  task automatic step(input int r, input int g, input int b, input bit v);
    exp_t e;
    int fn, q, mx, dl;
    i_red   = r[DW-1:0];
    i_green = g[DW-1:0];
    i_blue  = b[DW-1:0];
    i_valid = v;
    ref_px(r, g, b, fn, q, mx, dl);
    e.v = v; e.fn = fn[1:0]; e.d = q[15:0]; e.mx = mx[7:0]; e.dl = dl[7:0];
    @(posedge i_clk);
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    if (e.v) begin
      h_fn = e.fn; h_d = e.d; h_mx = e.mx; h_dl = e.dl;
    end
    chk("valid", {31'd0, o_valid}, {31'd0, e.v});
    chk("function", {30'd0, o_function}, {30'd0, h_fn});
    chk("data", {16'd0, o_data}, {16'd0, h_d});
`ifdef HUE_SV_OUT_EN
    chk("max", {24'd0, o_max}, {24'd0, h_mx});
    chk("delta", {24'd0, o_delta}, {24'd0, h_dl});
`endif
  endtask

  task automatic directed(input int r, input int g, input int b,
                          input logic [1:0] efn, input logic [15:0] ed);
    step(r, g, b, 1'b1);
    repeat (LAT) step(0, 0, 0, 1'b0);
    chk("dir_valid", {31'd0, o_valid}, 32'd1);
    chk("dir_function", {30'd0, o_function}, {30'd0, efn});
    chk("dir_data", {16'd0, o_data}, {16'd0, ed});
  endtask

  task automatic rand_px(output int r, output int g, output int b);
    r = int'($urandom_range(0, 255));
    g = ($urandom_range(0, 3) == 0) ? r : int'($urandom_range(0, 255));
    b = ($urandom_range(0, 3) == 0) ? g : int'($urandom_range(0, 255));
  endtask

  initial begin
    int r, g, b;
    #12;
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_data", {16'd0, o_data}, 32'd0);
    chk("reset_function", {30'd0, o_function}, 32'd0);
    i_rstn = 1'b1;
    model_reset();

    directed(255, 128, 0, 2'd1, 16'h0020);
`ifdef HUE_SV_OUT_EN
    chk("dir_max", {24'd0, o_max}, 32'd255);
    chk("dir_delta", {24'd0, o_delta}, 32'd255);
`endif
    directed(200, 0, 100, 2'd1, 16'hFFE0);
    directed(150, 50, 200, 2'd3, 16'h002A);
    directed(200, 200, 0, 2'd1, 16'h0040);
    directed(80, 80, 80, 2'd0, 16'h0000);
    directed(0, 200, 100, 2'd2, 16'h0020);

    for (int k = 0; k < 20; k++) begin
      rand_px(r, g, b);
      step(r, g, b, (k % 3) != 2);
    end

    for (int k = 0; k < 5; k++) begin
      rand_px(r, g, b);
      step(r, g, b, 1'b1);
    end
    #3;
    i_rstn  = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_data", {16'd0, o_data}, 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("in_rst_valid", {31'd0, o_valid}, 32'd0);
    #3;
    i_rstn = 1'b1;
    model_reset();
    directed(200, 0, 100, 2'd1, 16'hFFE0);

    for (int k = 0; k < 400; k++) begin
      rand_px(r, g, b);
      step(r, g, b, $urandom_range(0, 3) != 0);
    end
    repeat (LAT) step(0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
